cpu_step_controller: RTL and testbench

- Sits directly downstream of the frequency divider.
- Consumes the divider's slow square wave and the board's run/step/halt buttons.
- Produces a single-cycle clock-enable pulse for the RISC-V core, so the core advances at human-visible speed or one instruction per button press.
- Runs entirely in the fast board clock domain; the slow wave is treated as an asynchronous data input, never as a clock.

---
 rtl/cpu_step_pkg.sv | 13 +
 rtl/sync_rise_detect.sv | 27 ++
 rtl/cpu_step_controller.sv | 115 +++++++++++
 tb/tb_cpu_step_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_step_pkg.sv
// Shared types and defaults for the CPU step controller.
package cpu_step_pkg;

    typedef enum logic [1:0] {
        HALTED    = 2'd0,
        RUNNING   = 2'd1,
        STEP_WAIT = 2'd2
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_COUNT_W     = 16;

endpackage

// File: rtl/sync_rise_detect.sv
// Multi-stage synchronizer followed by a registered rising-edge pulse.
// All state resets to 1, so an input already high at reset release gives no pulse.
module sync_rise_detect #(
    parameter int unsigned STAGES = 2
) (
    input  logic clockOriginal,
    input  logic resetN,
    input  logic din,
    output logic pulse
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clockOriginal or negedge resetN) begin
        if (!resetN) begin
            chain <= '1;
            prev  <= 1'b1;
            pulse <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            pulse <= chain[STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/cpu_step_controller.sv
// Run/step/halt clock-enable generator for the core, paced by the divider's slow wave.
// Optional breakpoint stop is built when CPU_STEP_BREAKPOINT_EN is defined.
module cpu_step_controller
    import cpu_step_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned COUNT_W     = DEF_COUNT_W,
    parameter int unsigned PC_W        = 32
) (
    input  logic               clockOriginal,
    input  logic               resetN,
    input  logic               slowClock,
    input  logic               runButton,
    input  logic               stepButton,
    input  logic               haltButton,
    input  logic [PC_W-1:0]    pcValue,
    input  logic [PC_W-1:0]    breakpointAddr,
    output logic               cpuEnable,
    output logic               running,
    output logic [COUNT_W-1:0] cyclesExecuted,
    output logic               breakHit
);

    logic   tick, runP, stepP, haltP;
    logic   bpStop;
    logic   bpHit;
    logic   firstTick;
    state_t state;

    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_tick (
        .clockOriginal(clockOriginal), .resetN(resetN), .din(slowClock),  .pulse(tick)
    );
    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_run (
        .clockOriginal(clockOriginal), .resetN(resetN), .din(runButton),  .pulse(runP)
    );
    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_step (
        .clockOriginal(clockOriginal), .resetN(resetN), .din(stepButton), .pulse(stepP)
    );
    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_halt (
        .clockOriginal(clockOriginal), .resetN(resetN), .din(haltButton), .pulse(haltP)
    );

`ifdef CPU_STEP_BREAKPOINT_EN
    // First tick after leaving HALTED skips the compare so a step can execute the breakpoint instruction.
    assign bpStop   = !firstTick && (pcValue == breakpointAddr);
    assign breakHit = bpHit;
`else
    logic unused_bp;
    assign bpStop    = 1'b0;
    assign breakHit  = 1'b0;
    assign unused_bp = ^{pcValue, breakpointAddr, firstTick, bpHit};
`endif

    always_ff @(posedge clockOriginal or negedge resetN) begin
        if (!resetN) begin
            state          <= HALTED;
            cpuEnable      <= 1'b0;
            running        <= 1'b0;
            cyclesExecuted <= '0;
            bpHit          <= 1'b0;
            firstTick      <= 1'b0;
        end else begin
            cpuEnable <= 1'b0;
            if (cpuEnable && (cyclesExecuted != '1))
                cyclesExecuted <= cyclesExecuted + {{(COUNT_W-1){1'b0}}, 1'b1};

            case (state)
                HALTED: begin
                    if (!haltP) begin
                        if (stepP) begin
                            state     <= STEP_WAIT;
                            bpHit     <= 1'b0;
                            firstTick <= 1'b1;
                        end else if (runP) begin
                            state     <= RUNNING;
                            running   <= 1'b1;
                            bpHit     <= 1'b0;
                            firstTick <= 1'b1;
                        end
                    end
                end
                STEP_WAIT: begin
                    if (haltP) begin
                        state <= HALTED;
                    end else if (tick) begin
                        state     <= HALTED;
                        firstTick <= 1'b0;
                        if (bpStop) bpHit     <= 1'b1;
                        else        cpuEnable <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (haltP) begin
                        state   <= HALTED;
                        running <= 1'b0;
                    end else if (tick) begin
                        firstTick <= 1'b0;
                        if (bpStop) begin
                            bpHit   <= 1'b1;
                            state   <= HALTED;
                            running <= 1'b0;
                        end else begin
                            cpuEnable <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= HALTED;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed test of cpu_step_controller; a second instance with COUNT_W=4 covers saturation.
module tb_cpu_step_controller;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        slowClock = 1'b0;
    logic        runButton = 1'b0;
    logic        stepButton = 1'b0;
    logic        haltButton = 1'b0;
    logic [31:0] pcValue = 32'h0;
    logic [31:0] breakpointAddr = 32'h10;

    logic        cpuEnable, running, breakHit;
    logic [15:0] cyclesExecuted;
    logic        satEnable, satRunning, satBreak;
    logic [3:0]  satCycles;

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;
    int consec     = 0;
    int expCycles  = 0;
    int base;
    logic prevEn = 1'b0;

    cpu_step_controller #(.SYNC_STAGES(2), .COUNT_W(16), .PC_W(32)) dut (
        .clockOriginal(clk), .resetN(resetN), .slowClock(slowClock),
        .runButton(runButton), .stepButton(stepButton), .haltButton(haltButton),
        .pcValue(pcValue), .breakpointAddr(breakpointAddr),
        .cpuEnable(cpuEnable), .running(running),
        .cyclesExecuted(cyclesExecuted), .breakHit(breakHit)
    );

    cpu_step_controller #(.SYNC_STAGES(2), .COUNT_W(4), .PC_W(32)) dut_sat (
        .clockOriginal(clk), .resetN(resetN), .slowClock(slowClock),
        .runButton(runButton), .stepButton(stepButton), .haltButton(haltButton),
        .pcValue(pcValue), .breakpointAddr(breakpointAddr),
        .cpuEnable(satEnable), .running(satRunning),
        .cyclesExecuted(satCycles), .breakHit(satBreak)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpuEnable) pulses = pulses + 1;
        if (cpuEnable && prevEn) consec = consec + 1;
        prevEn = cpuEnable;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One slow-wave period of 20 cycles; enable is expected 4 edges after the rise.
    task automatic slow_pulse(input logic expect_en);
        @(negedge clk) slowClock = 1'b1;
        repeat (3) @(negedge clk);
        check("en_early", {31'b0, cpuEnable}, 32'd0);
        @(negedge clk);
        check("en_pulse", {31'b0, cpuEnable}, {31'b0, expect_en});
        @(negedge clk);
        check("en_single", {31'b0, cpuEnable}, 32'd0);
        repeat (5) @(negedge clk);
        slowClock = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic press(input int which);
        @(negedge clk);
        case (which)
            0: runButton  = 1'b1;
            1: stepButton = 1'b1;
            default: haltButton = 1'b1;
        endcase
        repeat (3) @(negedge clk);
        runButton = 1'b0; stepButton = 1'b0; haltButton = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_en",      {31'b0, cpuEnable}, 32'd0);
        check("rst_running", {31'b0, running}, 32'd0);
        check("rst_cycles",  {16'b0, cyclesExecuted}, 32'd0);
        check("rst_break",   {31'b0, breakHit}, 32'd0);
        resetN = 1'b1;
        repeat (5) @(negedge clk);

        // Idle: no buttons, slow wave alone does nothing
        for (int i = 0; i < 3; i++) slow_pulse(1'b0);
        check("idle_running", {31'b0, running}, 32'd0);
        check("idle_cycles",  {16'b0, cyclesExecuted}, 32'd0);

        // Run for five ticks
        press(0);
        check("run_running", {31'b0, running}, 32'd1);
        base = pulses;
        for (int i = 0; i < 5; i++) slow_pulse(1'b1);
        expCycles += 5;
        check("run_pulses", pulses - base, 32'd5);
        check("run_cycles", {16'b0, cyclesExecuted}, expCycles);

        // Halt and tick landing together: halt wins
        base = pulses;
        @(negedge clk) begin haltButton = 1'b1; slowClock = 1'b1; end
        repeat (12) @(negedge clk);
        check("halt_pulses",  pulses - base, 32'd0);
        check("halt_running", {31'b0, running}, 32'd0);
        slowClock = 1'b0;
        repeat (10) @(negedge clk);
        haltButton = 1'b0;
        repeat (5) @(negedge clk);
        check("halt_cycles", {16'b0, cyclesExecuted}, expCycles);

        // Single step: one pulse across three ticks
        press(1);
        base = pulses;
        slow_pulse(1'b1);
        slow_pulse(1'b0);
        slow_pulse(1'b0);
        expCycles += 1;
        check("step_pulses",  pulses - base, 32'd1);
        check("step_cycles",  {16'b0, cyclesExecuted}, expCycles);
        check("step_running", {31'b0, running}, 32'd0);

        // Twenty more ticks running: the 4-bit instance must saturate
        press(0);
        for (int i = 0; i < 20; i++) slow_pulse(1'b1);
        expCycles += 20;
        press(2);
        check("sat_main_cycles", {16'b0, cyclesExecuted}, expCycles);
        check("sat_cycles",      {28'b0, satCycles}, 32'd15);
        check("sat_running",     {31'b0, running}, 32'd0);

`ifdef CPU_STEP_BREAKPOINT_EN
        pcValue = 32'h0;
        press(0);
        slow_pulse(1'b1);
        expCycles += 1;
        pcValue = 32'h10;
        slow_pulse(1'b0);
        check("bp_hit",     {31'b0, breakHit}, 32'd1);
        check("bp_running", {31'b0, running}, 32'd0);
        press(1);
        check("bp_cleared", {31'b0, breakHit}, 32'd0);
        slow_pulse(1'b1);
        expCycles += 1;
        check("bp_cycles", {16'b0, cyclesExecuted}, expCycles);
`else
        check("bp_tied_low", {31'b0, breakHit}, 32'd0);
`endif

        // Reset while waiting for a step tick
        press(1);
        @(negedge clk) resetN = 1'b0;
        #1;
        check("mid_rst_en",      {31'b0, cpuEnable}, 32'd0);
        check("mid_rst_running", {31'b0, running}, 32'd0);
        check("mid_rst_cycles",  {16'b0, cyclesExecuted}, 32'd0);
        check("mid_rst_break",   {31'b0, breakHit}, 32'd0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        repeat (5) @(negedge clk);
        base = pulses;
        slow_pulse(1'b0);
        check("post_rst_pulses", pulses - base, 32'd0);
        check("post_rst_cycles", {16'b0, cyclesExecuted}, 32'd0);

        check("no_back_to_back", consec, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
